// File: rtl/demux_stream_1ton_pkg.sv
// Shared definitions for the 1-to-N stream demux: packet FSM states and drop counter width.
package demux_stream_1ton_pkg;

    localparam int unsigned DROP_CNT_W = 8;

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_IN_PKT = 1'b1
    } pkt_state_e;

endpackage

// File: rtl/demux_stream_1ton_slot.sv
// One-entry registered valid/ready buffer; drains and refills in the same cycle.
module demux_stream_1ton_slot #(
    parameter int unsigned W = 9
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         wr_en,
    input  logic [W-1:0] wr_data,
    output logic         free,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_data
);

    assign free = !out_valid || out_ready;

    // Writer only asserts wr_en while free, so a write always wins over a drain.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_data  <= '0;
        end else if (wr_en) begin
            out_valid <= 1'b1;
            out_data  <= wr_data;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: rtl/demux_stream_1ton.sv
// Routes a valid/ready stream to one of NCH buffered outputs, with optional per-packet route
// locking; beats selecting a nonexistent channel are accepted, discarded and counted.
module demux_stream_1ton
    import demux_stream_1ton_pkg::*;
#(
    parameter int unsigned DATA_W   = 8,
    parameter int unsigned NCH      = 4,
    parameter int unsigned SEL_W    = 2,
    parameter bit          PKT_MODE = 1'b1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [DATA_W-1:0]       in_data,
    input  logic                    in_last,
    input  logic [SEL_W-1:0]        in_sel,
    output logic [NCH-1:0]          out_valid,
    input  logic [NCH-1:0]          out_ready,
    output logic [NCH*DATA_W-1:0]   out_data,
    output logic [NCH-1:0]          out_last,
    output logic                    drop_pulse,
    output logic [DROP_CNT_W-1:0]   drop_cnt
);

    localparam logic [SEL_W:0] NCH_CMP = (SEL_W+1)'(NCH);

    pkt_state_e       state, state_nxt;
    logic [SEL_W-1:0] route_q, route_nxt, route;
    logic             in_range, route_free, accept, drop;
    logic [NCH-1:0]   slot_free, slot_wr;

    always_comb begin
        route = (!PKT_MODE || state == ST_IDLE) ? in_sel : route_q;
    end

    always_comb begin
        in_range   = ({1'b0, route} < NCH_CMP);
        route_free = 1'b0;
        for (int unsigned k = 0; k < NCH; k++) begin
            if (route == SEL_W'(k)) route_free = slot_free[k];
        end
        in_ready = in_range ? route_free : 1'b1;
        accept   = in_valid && in_ready;
        drop     = accept && !in_range;
        for (int unsigned k = 0; k < NCH; k++) begin
            slot_wr[k] = accept && in_range && (route == SEL_W'(k));
        end
    end

    // Out-of-range selects are latched too, so the remainder of such a packet is dropped.
    always_comb begin
        state_nxt = state;
        route_nxt = route_q;
        if (PKT_MODE && accept) begin
            unique case (state)
                ST_IDLE: begin
                    if (!in_last) begin
                        state_nxt = ST_IN_PKT;
                        route_nxt = in_sel;
                    end
                end
                ST_IN_PKT: begin
                    if (in_last) state_nxt = ST_IDLE;
                end
                default: state_nxt = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= ST_IDLE;
            route_q <= '0;
        end else begin
            state   <= state_nxt;
            route_q <= route_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            drop_pulse <= 1'b0;
            drop_cnt   <= '0;
        end else begin
            drop_pulse <= drop;
            if (drop && drop_cnt != '1) drop_cnt <= drop_cnt + 1'b1;
        end
    end

    for (genvar k = 0; k < NCH; k++) begin : g_slot
        logic [DATA_W:0] slot_q;

        demux_stream_1ton_slot #(
            .W(DATA_W + 1)
        ) u_slot (
            .clk       (clk),
            .rst       (rst),
            .wr_en     (slot_wr[k]),
            .wr_data   ({in_last, in_data}),
            .free      (slot_free[k]),
            .out_valid (out_valid[k]),
            .out_ready (out_ready[k]),
            .out_data  (slot_q)
        );

        assign out_data[k*DATA_W +: DATA_W] = slot_q[DATA_W-1:0];
        assign out_last[k]                  = slot_q[DATA_W];
    end

endmodule
